// File: rtl/decoder_issue_stage_pkg.sv
// ============================================================================
// Module  : decoder_issue_stage_pkg
// Brief   : Shared constants, one-hot indices and FSM encoding for the
//           RV32I decode/issue stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package decoder_issue_stage_pkg;

   localparam int OPCODE_WIDTH    = 11;
   localparam int ALU_WIDTH       = 14;
   localparam int EXCEPTION_WIDTH = 4;

   // One-hot opcode-class bit positions
   localparam int OP_RTYPE  = 0;
   localparam int OP_ITYPE  = 1;
   localparam int OP_LOAD   = 2;
   localparam int OP_STORE  = 3;
   localparam int OP_BRANCH = 4;
   localparam int OP_JAL    = 5;
   localparam int OP_JALR   = 6;
   localparam int OP_LUI    = 7;
   localparam int OP_AUIPC  = 8;
   localparam int OP_SYSTEM = 9;
   localparam int OP_FENCE  = 10;

   // One-hot ALU operation bit positions
   localparam int A_ADD  = 0;
   localparam int A_SUB  = 1;
   localparam int A_SLT  = 2;
   localparam int A_SLTU = 3;
   localparam int A_XOR  = 4;
   localparam int A_OR   = 5;
   localparam int A_AND  = 6;
   localparam int A_SLL  = 7;
   localparam int A_SRL  = 8;
   localparam int A_SRA  = 9;
   localparam int A_EQ   = 10;
   localparam int A_NEQ  = 11;
   localparam int A_GE   = 12;
   localparam int A_GEU  = 13;

   localparam int EXC_ILLEGAL = 0;
   localparam int EXC_ECALL   = 1;
   localparam int EXC_EBREAK  = 2;
   localparam int EXC_MRET    = 3;

   localparam logic [6:0] RV_OP       = 7'b0110011;
   localparam logic [6:0] RV_OP_IMM   = 7'b0010011;
   localparam logic [6:0] RV_LOAD     = 7'b0000011;
   localparam logic [6:0] RV_STORE    = 7'b0100011;
   localparam logic [6:0] RV_BRANCH   = 7'b1100011;
   localparam logic [6:0] RV_JAL      = 7'b1101111;
   localparam logic [6:0] RV_JALR     = 7'b1100111;
   localparam logic [6:0] RV_LUI      = 7'b0110111;
   localparam logic [6:0] RV_AUIPC    = 7'b0010111;
   localparam logic [6:0] RV_SYSTEM   = 7'b1110011;
   localparam logic [6:0] RV_MISC_MEM = 7'b0001111;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } ds_state_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
      logic [31:0] imm;
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   imm = {ins[31:12], 12'b0};
         IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_issue_stage_if.sv
// ============================================================================
// Module  : decoder_issue_stage_if
// Brief   : Fetch-side, write-back and issue-side signals of the decode stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface decoder_issue_stage_if #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 5,
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32
);
   import decoder_issue_stage_pkg::*;

   logic [IWIDTH-1:0]          ds_i_instr;
   logic [PC_WIDTH-1:0]        ds_i_pc;
   logic                       ds_i_ce;
   logic                       ds_i_stall;
   logic                       ds_i_flush;
   logic                       ds_i_wb_we;
   logic [AWIDTH-1:0]          ds_i_wb_addr;
   logic [DWIDTH-1:0]          ds_i_wb_data;

   logic [PC_WIDTH-1:0]        ds_o_pc;
   logic [AWIDTH-1:0]          ds_o_addr_rs1_p;
   logic [AWIDTH-1:0]          ds_o_addr_rs2_p;
   logic [AWIDTH-1:0]          ds_o_addr_rd_p;
   logic [DWIDTH-1:0]          ds_o_data_rs1;
   logic [DWIDTH-1:0]          ds_o_data_rs2;
   logic [2:0]                 ds_o_funct3;
   logic [DWIDTH-1:0]          ds_o_imm;
   logic [ALU_WIDTH-1:0]       ds_o_alu;
   logic [OPCODE_WIDTH-1:0]    ds_o_opcode;
   logic [EXCEPTION_WIDTH-1:0] ds_o_exception;
   logic                       ds_o_ce;
   logic                       ds_o_stall;
   logic                       ds_o_flush;

   modport master (
      output ds_i_instr, ds_i_pc, ds_i_ce, ds_i_stall, ds_i_flush,
             ds_i_wb_we, ds_i_wb_addr, ds_i_wb_data,
      input  ds_o_pc, ds_o_addr_rs1_p, ds_o_addr_rs2_p, ds_o_addr_rd_p,
             ds_o_data_rs1, ds_o_data_rs2, ds_o_funct3, ds_o_imm, ds_o_alu,
             ds_o_opcode, ds_o_exception, ds_o_ce, ds_o_stall, ds_o_flush
   );

   modport slave (
      input  ds_i_instr, ds_i_pc, ds_i_ce, ds_i_stall, ds_i_flush,
             ds_i_wb_we, ds_i_wb_addr, ds_i_wb_data,
      output ds_o_pc, ds_o_addr_rs1_p, ds_o_addr_rs2_p, ds_o_addr_rd_p,
             ds_o_data_rs1, ds_o_data_rs2, ds_o_funct3, ds_o_imm, ds_o_alu,
             ds_o_opcode, ds_o_exception, ds_o_ce, ds_o_stall, ds_o_flush
   );

endinterface

`default_nettype wire

// File: rtl/decoder_issue_stage_regfile.sv
// ============================================================================
// Module  : decoder_issue_stage_regfile
// Brief   : DEPTH x DWIDTH register file, 2 async reads, 1 sync write, x0=0.
//           Macro DS_WB_BYPASS_EN forwards same-cycle write data to reads.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module decoder_issue_stage_regfile #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5,
   parameter int DEPTH  = 1 << AWIDTH
) (
   input  wire logic              i_clk,
   input  wire logic              i_we,
   input  wire logic [AWIDTH-1:0] i_waddr,
   input  wire logic [DWIDTH-1:0] i_wdata,
   input  wire logic [AWIDTH-1:0] i_raddr1,
   input  wire logic [AWIDTH-1:0] i_raddr2,
   output logic      [DWIDTH-1:0] o_rdata1,
   output logic      [DWIDTH-1:0] o_rdata2
);

   logic [DWIDTH-1:0] r_mem [DEPTH];

   // Storage is deliberately not reset
   always_ff @(posedge i_clk) begin
      if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

`ifdef DS_WB_BYPASS_EN
   logic w_byp1;
   logic w_byp2;
   assign w_byp1   = i_we && (i_waddr != '0) && (i_waddr == i_raddr1);
   assign w_byp2   = i_we && (i_waddr != '0) && (i_waddr == i_raddr2);
   assign o_rdata1 = (i_raddr1 == '0) ? '0 : (w_byp1 ? i_wdata : r_mem[i_raddr1]);
   assign o_rdata2 = (i_raddr2 == '0) ? '0 : (w_byp2 ? i_wdata : r_mem[i_raddr2]);
`else
   assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
`endif

endmodule

`default_nettype wire

// File: rtl/decoder_issue_stage.sv
// ============================================================================
// Module  : decoder_issue_stage
// Brief   : RV32I decode/issue stage with regfile, load-use bubble FSM and a
//           stall/flush-aware output register. Option macro: DS_WB_BYPASS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module decoder_issue_stage
   import decoder_issue_stage_pkg::*;
#(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 5,
   parameter int DEPTH    = 1 << AWIDTH,
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32
) (
   input wire logic             ds_clk,
   input wire logic             ds_rst,
   decoder_issue_stage_if.slave bus
);

   logic [31:0]                w_ins;
   logic [6:0]                 w_op;
   logic [2:0]                 w_f3;
   logic [6:0]                 w_f7;
   logic [AWIDTH-1:0]          w_rs1;
   logic [AWIDTH-1:0]          w_rs2;
   logic [AWIDTH-1:0]          w_rd;
   logic [DWIDTH-1:0]          w_rdata1;
   logic [DWIDTH-1:0]          w_rdata2;
   logic [DWIDTH-1:0]          w_imm;
   logic [OPCODE_WIDTH-1:0]    w_opc;
   logic [ALU_WIDTH-1:0]       w_alu;
   logic [EXCEPTION_WIDTH-1:0] w_exc;
   imm_fmt_e                   w_fmt;
   logic                       w_illegal;
   logic                       w_ecall;
   logic                       w_ebreak;
   logic                       w_mret;
   logic                       w_uses_rs2;
   logic                       w_hazard;
   ds_state_e                  r_state;
   ds_state_e                  w_state_nxt;

   logic [PC_WIDTH-1:0]        r_pc;
   logic [AWIDTH-1:0]          r_rs1;
   logic [AWIDTH-1:0]          r_rs2;
   logic [AWIDTH-1:0]          r_rd;
   logic [DWIDTH-1:0]          r_data1;
   logic [DWIDTH-1:0]          r_data2;
   logic [2:0]                 r_f3;
   logic [DWIDTH-1:0]          r_imm;
   logic [ALU_WIDTH-1:0]       r_alu;
   logic [OPCODE_WIDTH-1:0]    r_opc;
   logic [EXCEPTION_WIDTH-1:0] r_exc;
   logic                       r_ce;
   logic                       r_flush;

   assign w_ins = 32'(bus.ds_i_instr);
   assign w_op  = w_ins[6:0];
   assign w_f3  = w_ins[14:12];
   assign w_f7  = w_ins[31:25];
   assign w_rs1 = AWIDTH'(w_ins[19:15]);
   assign w_rs2 = AWIDTH'(w_ins[24:20]);
   assign w_rd  = AWIDTH'(w_ins[11:7]);

   decoder_issue_stage_regfile #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .DEPTH  (DEPTH)
   ) u_regfile (
      .i_clk    (ds_clk),
      .i_we     (bus.ds_i_wb_we),
      .i_waddr  (bus.ds_i_wb_addr),
      .i_wdata  (bus.ds_i_wb_data),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rdata1),
      .o_rdata2 (w_rdata2)
   );

   always_comb begin
      w_opc      = '0;
      w_alu      = '0;
      w_fmt      = IMM_NONE;
      w_illegal  = 1'b0;
      w_ecall    = 1'b0;
      w_ebreak   = 1'b0;
      w_mret     = 1'b0;
      w_uses_rs2 = 1'b0;
      case (w_op)
         RV_OP: begin
            w_opc[OP_RTYPE] = 1'b1;
            w_uses_rs2      = 1'b1;
            case ({w_f7, w_f3})
               {7'b0000000, 3'b000}: w_alu[A_ADD]  = 1'b1;
               {7'b0100000, 3'b000}: w_alu[A_SUB]  = 1'b1;
               {7'b0000000, 3'b001}: w_alu[A_SLL]  = 1'b1;
               {7'b0000000, 3'b010}: w_alu[A_SLT]  = 1'b1;
               {7'b0000000, 3'b011}: w_alu[A_SLTU] = 1'b1;
               {7'b0000000, 3'b100}: w_alu[A_XOR]  = 1'b1;
               {7'b0000000, 3'b101}: w_alu[A_SRL]  = 1'b1;
               {7'b0100000, 3'b101}: w_alu[A_SRA]  = 1'b1;
               {7'b0000000, 3'b110}: w_alu[A_OR]   = 1'b1;
               {7'b0000000, 3'b111}: w_alu[A_AND]  = 1'b1;
               default:              w_illegal     = 1'b1;
            endcase
         end
         RV_OP_IMM: begin
            w_opc[OP_ITYPE] = 1'b1;
            w_fmt           = IMM_I;
            case (w_f3)
               3'b000: w_alu[A_ADD]  = 1'b1;
               3'b010: w_alu[A_SLT]  = 1'b1;
               3'b011: w_alu[A_SLTU] = 1'b1;
               3'b100: w_alu[A_XOR]  = 1'b1;
               3'b110: w_alu[A_OR]   = 1'b1;
               3'b111: w_alu[A_AND]  = 1'b1;
               3'b001: if (w_f7 == 7'b0000000) w_alu[A_SLL] = 1'b1; else w_illegal = 1'b1;
               default: begin
                  if (w_f7 == 7'b0000000)      w_alu[A_SRL] = 1'b1;
                  else if (w_f7 == 7'b0100000) w_alu[A_SRA] = 1'b1;
                  else                         w_illegal    = 1'b1;
               end
            endcase
         end
         RV_LOAD: begin
            w_opc[OP_LOAD] = 1'b1;
            w_fmt          = IMM_I;
            w_alu[A_ADD]   = 1'b1;
            w_illegal      = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         RV_STORE: begin
            w_opc[OP_STORE] = 1'b1;
            w_fmt           = IMM_S;
            w_uses_rs2      = 1'b1;
            w_alu[A_ADD]    = 1'b1;
            w_illegal       = (w_f3 > 3'b010);
         end
         RV_BRANCH: begin
            w_opc[OP_BRANCH] = 1'b1;
            w_fmt            = IMM_B;
            w_uses_rs2       = 1'b1;
            case (w_f3)
               3'b000:  w_alu[A_EQ]   = 1'b1;
               3'b001:  w_alu[A_NEQ]  = 1'b1;
               3'b100:  w_alu[A_SLT]  = 1'b1;
               3'b101:  w_alu[A_GE]   = 1'b1;
               3'b110:  w_alu[A_SLTU] = 1'b1;
               3'b111:  w_alu[A_GEU]  = 1'b1;
               default: w_illegal     = 1'b1;
            endcase
         end
         RV_JAL: begin
            w_opc[OP_JAL] = 1'b1;
            w_fmt         = IMM_J;
            w_alu[A_ADD]  = 1'b1;
         end
         RV_JALR: begin
            w_opc[OP_JALR] = 1'b1;
            w_fmt          = IMM_I;
            w_alu[A_ADD]   = 1'b1;
            w_illegal      = (w_f3 != 3'b000);
         end
         RV_LUI: begin
            w_opc[OP_LUI] = 1'b1;
            w_fmt         = IMM_U;
            w_alu[A_ADD]  = 1'b1;
         end
         RV_AUIPC: begin
            w_opc[OP_AUIPC] = 1'b1;
            w_fmt           = IMM_U;
            w_alu[A_ADD]    = 1'b1;
         end
         RV_SYSTEM: begin
            w_opc[OP_SYSTEM] = 1'b1;
            w_fmt            = IMM_I;
            // CSR accesses pass through; only the exact trap encodings are recognised
            if (w_ins == INSTR_ECALL)       w_ecall   = 1'b1;
            else if (w_ins == INSTR_EBREAK) w_ebreak  = 1'b1;
            else if (w_ins == INSTR_MRET)   w_mret    = 1'b1;
            else if ((w_f3 == 3'b000) || (w_f3 == 3'b100)) w_illegal = 1'b1;
         end
         RV_MISC_MEM: begin
            w_opc[OP_FENCE] = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      if (w_illegal) begin
         w_alu = '0;
      end
   end

   assign w_imm = DWIDTH'($signed(imm_gen(w_ins, w_fmt)));
   assign w_exc = {w_mret, w_ebreak, w_ecall, w_illegal};

   assign w_hazard = (r_state == ST_RUN) && bus.ds_i_ce && r_ce && r_opc[OP_LOAD]
                   && (r_rd != '0)
                   && ((w_rs1 == r_rd) || (w_uses_rs2 && (w_rs2 == r_rd)));

   assign bus.ds_o_stall = bus.ds_i_stall | w_hazard;

   always_comb begin
      w_state_nxt = r_state;
      if (bus.ds_i_flush)       w_state_nxt = ST_RUN;
      else if (bus.ds_i_stall)  w_state_nxt = r_state;
      else if (w_hazard)        w_state_nxt = ST_BUBBLE;
      else                      w_state_nxt = ST_RUN;
   end

   always_ff @(posedge ds_clk or negedge ds_rst) begin
      if (!ds_rst) r_state <= ST_RUN;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge ds_clk or negedge ds_rst) begin
      if (!ds_rst) begin
         r_pc    <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
         r_data1 <= '0;
         r_data2 <= '0;
         r_f3    <= '0;
         r_imm   <= '0;
         r_alu   <= '0;
         r_opc   <= '0;
         r_exc   <= '0;
         r_ce    <= 1'b0;
         r_flush <= 1'b0;
      end else if (bus.ds_i_flush) begin
         r_ce    <= 1'b0;
         r_flush <= 1'b1;
      end else begin
         r_flush <= 1'b0;
         if (!bus.ds_i_stall) begin
            if (w_hazard) begin
               r_ce <= 1'b0;
            end else begin
               r_pc    <= bus.ds_i_pc;
               r_rs1   <= w_rs1;
               r_rs2   <= w_rs2;
               r_rd    <= w_rd;
               r_data1 <= w_rdata1;
               r_data2 <= w_rdata2;
               r_f3    <= w_f3;
               r_imm   <= w_imm;
               r_alu   <= w_alu;
               r_opc   <= w_opc;
               r_exc   <= w_exc;
               r_ce    <= bus.ds_i_ce;
            end
         end
      end
   end

   assign bus.ds_o_pc         = r_pc;
   assign bus.ds_o_addr_rs1_p = r_rs1;
   assign bus.ds_o_addr_rs2_p = r_rs2;
   assign bus.ds_o_addr_rd_p  = r_rd;
   assign bus.ds_o_data_rs1   = r_data1;
   assign bus.ds_o_data_rs2   = r_data2;
   assign bus.ds_o_funct3     = r_f3;
   assign bus.ds_o_imm        = r_imm;
   assign bus.ds_o_alu        = r_alu;
   assign bus.ds_o_opcode     = r_opc;
   assign bus.ds_o_exception  = r_exc;
   assign bus.ds_o_ce         = r_ce;
   assign bus.ds_o_flush      = r_flush;

endmodule

`default_nettype wire

// File: tb/tb_decoder_issue_stage.sv
// ============================================================================
// Module  : tb_decoder_issue_stage
// Brief   : Directed, table-driven self-checking bench for decoder_issue_stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_decoder_issue_stage;
   import decoder_issue_stage_pkg::*;

   logic ds_clk = 1'b0;
   logic ds_rst = 1'b0;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 ds_clk = ~ds_clk;

   decoder_issue_stage_if #(.DWIDTH(32), .AWIDTH(5), .PC_WIDTH(32), .IWIDTH(32)) bus ();

   decoder_issue_stage #(
      .DWIDTH(32), .AWIDTH(5), .DEPTH(32), .PC_WIDTH(32), .IWIDTH(32)
   ) dut (
      .ds_clk (ds_clk),
      .ds_rst (ds_rst),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] imm;
      int          alu;
      int          opc;
      logic [3:0]  exc;
   } vec_t;

   vec_t vecs[14];

   task automatic tick();
      @(posedge ds_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] onehot(input int idx);
      return (idx < 0) ? 64'd0 : (64'd1 << idx);
   endfunction

   initial begin
      logic [31:0] old_x4;
      vecs[0]  = '{32'h003100B3, 5'd2,  5'd3,  5'd1,  3'd0, 32'h00000000, A_ADD, OP_RTYPE,  4'h0};
      vecs[1]  = '{32'hFFF20393, 5'd4,  5'd31, 5'd7,  3'd0, 32'hFFFFFFFF, A_ADD, OP_ITYPE,  4'h0};
      vecs[2]  = '{32'h00802283, 5'd0,  5'd8,  5'd5,  3'd2, 32'h00000008, A_ADD, OP_LOAD,   4'h0};
      vecs[3]  = '{32'hFE612E23, 5'd2,  5'd6,  5'd28, 3'd2, 32'hFFFFFFFC, A_ADD, OP_STORE,  4'h0};
      vecs[4]  = '{32'hFE208CE3, 5'd1,  5'd2,  5'd25, 3'd0, 32'hFFFFFFF8, A_EQ,  OP_BRANCH, 4'h0};
      vecs[5]  = '{32'h12345537, 5'd8,  5'd3,  5'd10, 3'd5, 32'h12345000, A_ADD, OP_LUI,    4'h0};
      vecs[6]  = '{32'h001000EF, 5'd0,  5'd1,  5'd1,  3'd0, 32'h00000800, A_ADD, OP_JAL,    4'h0};
      vecs[7]  = '{32'h40A48433, 5'd9,  5'd10, 5'd8,  3'd0, 32'h00000000, A_SUB, OP_RTYPE,  4'h0};
      vecs[8]  = '{32'h4030D093, 5'd1,  5'd3,  5'd1,  3'd5, 32'h00000403, A_SRA, OP_ITYPE,  4'h0};
      vecs[9]  = '{32'h0000007F, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000000, -1,    -1,        4'h1};
      vecs[10] = '{32'h00000073, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000000, -1,    OP_SYSTEM, 4'h2};
      vecs[11] = '{32'h023100B3, 5'd2,  5'd3,  5'd1,  3'd0, 32'h00000000, -1,    OP_RTYPE,  4'h1};
      vecs[12] = '{32'h30200073, 5'd0,  5'd2,  5'd0,  3'd0, 32'h00000302, -1,    OP_SYSTEM, 4'h8};
      vecs[13] = '{32'h00100073, 5'd0,  5'd1,  5'd0,  3'd0, 32'h00000001, -1,    OP_SYSTEM, 4'h4};

      bus.ds_i_instr = '0; bus.ds_i_pc = '0; bus.ds_i_ce = 1'b0;
      bus.ds_i_stall = 1'b0; bus.ds_i_flush = 1'b0;
      bus.ds_i_wb_we = 1'b0; bus.ds_i_wb_addr = '0; bus.ds_i_wb_data = '0;

      tick(); tick();
      chk("rst_ce",    64'(bus.ds_o_ce), 64'd0);
      chk("rst_pc",    64'(bus.ds_o_pc), 64'd0);
      chk("rst_flush", 64'(bus.ds_o_flush), 64'd0);
      chk("rst_imm",   64'(bus.ds_o_imm), 64'd0);
      chk("rst_stall", 64'(bus.ds_o_stall), 64'd0);
      ds_rst = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         bus.ds_i_instr = vecs[i].instr;
         bus.ds_i_pc    = 32'h100 + 32'(i * 4);
         bus.ds_i_ce    = 1'b1;
         tick();
         chk($sformatf("v%0d_ce", i),  64'(bus.ds_o_ce), 64'd1);
         chk($sformatf("v%0d_pc", i),  64'(bus.ds_o_pc), 64'(32'h100 + 32'(i * 4)));
         chk($sformatf("v%0d_rs1", i), 64'(bus.ds_o_addr_rs1_p), 64'(vecs[i].rs1));
         chk($sformatf("v%0d_rs2", i), 64'(bus.ds_o_addr_rs2_p), 64'(vecs[i].rs2));
         chk($sformatf("v%0d_rd", i),  64'(bus.ds_o_addr_rd_p), 64'(vecs[i].rd));
         chk($sformatf("v%0d_f3", i),  64'(bus.ds_o_funct3), 64'(vecs[i].f3));
         chk($sformatf("v%0d_imm", i), 64'(bus.ds_o_imm), 64'(vecs[i].imm));
         chk($sformatf("v%0d_alu", i), 64'(bus.ds_o_alu), onehot(vecs[i].alu));
         chk($sformatf("v%0d_opc", i), 64'(bus.ds_o_opcode), onehot(vecs[i].opc));
         chk($sformatf("v%0d_exc", i), 64'(bus.ds_o_exception), 64'(vecs[i].exc));
         bus.ds_i_ce = 1'b0;
         tick();
         chk($sformatf("v%0d_idle_ce", i), 64'(bus.ds_o_ce), 64'd0);
      end

      // Register writes then add x1,x2,x3 at pc=4
      bus.ds_i_wb_we = 1'b1; bus.ds_i_wb_addr = 5'd2; bus.ds_i_wb_data = 32'd5;
      tick();
      bus.ds_i_wb_addr = 5'd3; bus.ds_i_wb_data = 32'd7;
      tick();
      bus.ds_i_wb_addr = 5'd0; bus.ds_i_wb_data = 32'hFFFF_FFFF;
      tick();
      bus.ds_i_wb_we = 1'b0;
      bus.ds_i_instr = 32'h003100B3; bus.ds_i_pc = 32'd4; bus.ds_i_ce = 1'b1;
      tick();
      chk("add_ce",    64'(bus.ds_o_ce), 64'd1);
      chk("add_pc",    64'(bus.ds_o_pc), 64'd4);
      chk("add_data1", 64'(bus.ds_o_data_rs1), 64'd5);
      chk("add_data2", 64'(bus.ds_o_data_rs2), 64'd7);
      bus.ds_i_instr = 32'h00000033;
      tick();
      chk("x0_read_zero", 64'(bus.ds_o_data_rs1), 64'd0);
      bus.ds_i_ce = 1'b0;
      tick();

      // Load-use hazard: lw x5,8(x0) followed by add x6,x5,x1
      bus.ds_i_instr = 32'h00802283; bus.ds_i_pc = 32'h20; bus.ds_i_ce = 1'b1;
      tick();
      bus.ds_i_instr = 32'h00128333; bus.ds_i_pc = 32'h24;
      #1;
      chk("lu_stall", 64'(bus.ds_o_stall), 64'd1);
      tick();
      chk("lu_bubble_ce", 64'(bus.ds_o_ce), 64'd0);
      chk("lu_bubble_rd", 64'(bus.ds_o_addr_rd_p), 64'd5);
      chk("lu_stall_rel", 64'(bus.ds_o_stall), 64'd0);
      tick();
      chk("lu_issue_ce",  64'(bus.ds_o_ce), 64'd1);
      chk("lu_issue_rs1", 64'(bus.ds_o_addr_rs1_p), 64'd5);
      chk("lu_issue_rd",  64'(bus.ds_o_addr_rd_p), 64'd6);
      chk("lu_issue_pc",  64'(bus.ds_o_pc), 64'h24);
      bus.ds_i_ce = 1'b0;
      tick();

      // Load targeting x0 never stalls
      bus.ds_i_instr = 32'h00802003; bus.ds_i_ce = 1'b1;
      tick();
      bus.ds_i_instr = 32'h00100333;
      #1;
      chk("lu_x0_stall", 64'(bus.ds_o_stall), 64'd0);
      tick();
      chk("lu_x0_ce", 64'(bus.ds_o_ce), 64'd1);
      chk("lu_x0_rd", 64'(bus.ds_o_addr_rd_p), 64'd6);
      bus.ds_i_ce = 1'b0;
      tick();

      // Flush
      bus.ds_i_instr = 32'hFFF20393; bus.ds_i_ce = 1'b1; bus.ds_i_flush = 1'b1;
      tick();
      chk("fl_ce",    64'(bus.ds_o_ce), 64'd0);
      chk("fl_flush", 64'(bus.ds_o_flush), 64'd1);
      bus.ds_i_flush = 1'b0; bus.ds_i_ce = 1'b0;
      tick();
      chk("fl_clear", 64'(bus.ds_o_flush), 64'd0);

      // Downstream stall holds outputs for 3 cycles
      bus.ds_i_instr = 32'hFFF20393; bus.ds_i_pc = 32'h200; bus.ds_i_ce = 1'b1;
      tick();
      chk("st_pc0", 64'(bus.ds_o_pc), 64'h200);
      bus.ds_i_stall = 1'b1;
      bus.ds_i_instr = 32'h12345537; bus.ds_i_pc = 32'h204;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("st_ostall%0d", k), 64'(bus.ds_o_stall), 64'd1);
         tick();
         chk($sformatf("st_pc%0d", k + 1), 64'(bus.ds_o_pc), 64'h200);
         chk($sformatf("st_opc%0d", k + 1), 64'(bus.ds_o_opcode), onehot(OP_ITYPE));
      end
      bus.ds_i_stall = 1'b0;
      tick();
      chk("st_rel_pc",  64'(bus.ds_o_pc), 64'h204);
      chk("st_rel_opc", 64'(bus.ds_o_opcode), onehot(OP_LUI));
      chk("st_rel_ce",  64'(bus.ds_o_ce), 64'd1);
      bus.ds_i_ce = 1'b0;
      tick();

      // Same-cycle write-back vs decode of addi x7,x4,-1
      old_x4 = 32'h1111_1111;
      bus.ds_i_wb_we = 1'b1; bus.ds_i_wb_addr = 5'd4; bus.ds_i_wb_data = old_x4;
      tick();
      bus.ds_i_wb_data = 32'hDEADBEEF;
      bus.ds_i_instr = 32'hFFF20393; bus.ds_i_pc = 32'h300; bus.ds_i_ce = 1'b1;
      tick();
      bus.ds_i_wb_we = 1'b0;
`ifdef DS_WB_BYPASS_EN
      chk("byp_data1", 64'(bus.ds_o_data_rs1), 64'hDEADBEEF);
`else
      chk("byp_data1", 64'(bus.ds_o_data_rs1), 64'(old_x4));
`endif
      chk("byp_imm", 64'(bus.ds_o_imm), 64'hFFFFFFFF);
      tick();
      chk("byp_after", 64'(bus.ds_o_data_rs1), 64'hDEADBEEF);

      // Asynchronous reset mid-stream
      #2;
      ds_rst = 1'b0;
      #1;
      chk("arst_ce",    64'(bus.ds_o_ce), 64'd0);
      chk("arst_pc",    64'(bus.ds_o_pc), 64'd0);
      chk("arst_data1", 64'(bus.ds_o_data_rs1), 64'd0);
      chk("arst_imm",   64'(bus.ds_o_imm), 64'd0);
      bus.ds_i_ce = 1'b0;
      tick();
      ds_rst = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/decoder_issue_stage.md
Name: decoder_issue_stage

Overview:
Parametrised successor to the decode stage of the in-order RISC-V pipeline. Sits between fetch and execute.
- Decodes RV32I instructions and reads an integrated DEPTH-entry register file through a dedicated write-back port.
- Detects load-use hazards with a 2-state FSM that inserts a bubble.
- Registers all results into a stall/flush-aware pipeline register.

Parameters:
DWIDTH, 32, register/data width
AWIDTH, 5, register address width
DEPTH, 1<<AWIDTH, register file entries (x0 hardwired zero)
PC_WIDTH, 32, program counter width
IWIDTH, 32, instruction width

Ports:
ds_clk  in  1  clock, rising edge
ds_rst  in  1  asynchronous reset, active-low
ds_i_instr  in  IWIDTH  instruction from fetch
ds_i_pc  in  PC_WIDTH  PC of ds_i_instr
ds_i_ce  in  1  ds_i_instr valid
ds_i_stall  in  1  downstream stall
ds_i_flush  in  1  flush (branch/exception redirect)
ds_i_wb_we  in  1  register file write enable
ds_i_wb_addr  in  AWIDTH  write address
ds_i_wb_data  in  DWIDTH  write data
ds_o_pc  out  PC_WIDTH  registered PC
ds_o_addr_rs1_p / ds_o_addr_rs2_p / ds_o_addr_rd_p  out  AWIDTH  registered register addresses
ds_o_data_rs1 / ds_o_data_rs2  out  DWIDTH  registered operand values
ds_o_funct3  out  3  registered funct3
ds_o_imm  out  DWIDTH  sign-extended immediate
ds_o_alu  out  ALU_WIDTH  one-hot ALU op
ds_o_opcode  out  OPCODE_WIDTH  one-hot opcode class
ds_o_exception  out  EXCEPTION_WIDTH  {mret, ebreak, ecall, illegal}
ds_o_ce  out  1  output valid
ds_o_stall  out  1  stall to fetch (combinational)
ds_o_flush  out  1  registered flush

Behaviour:
- Reset (ds_rst=0, asynchronous): every registered output = 0, FSM = RUN. Register file contents are not reset; reads of x0 always return 0, and writes to x0 are ignored.
- Register file writes are synchronous on ds_i_wb_we. Reads are combinational from ds_i_instr[19:15]/[24:20] and are captured in the output register.
- Immediate formats: I/S/B/U/J, sign-extended to DWIDTH. B and J immediates have bit0=0.
- Unknown opcode, or an illegal funct3/funct7 combination: illegal=1, ds_o_alu=0. The instruction still issues with ds_o_ce=1.
- Latency: 1 cycle from accepted input to ds_o_*.
- hazard = FSM==RUN & ds_i_ce & ds_o_ce & ds_o_opcode==LOAD & ds_o_addr_rd_p!=0 & (rs1 match, or rs2 match when the opcode uses rs2: R/store/branch).
- ds_o_stall = ds_i_stall | hazard.
- Priority per posedge:
  1. ds_i_flush: ds_o_ce<=0, ds_o_flush<=1, FSM<=RUN.
  2. ds_i_stall: all output registers hold.
  3. hazard: ds_o_ce<=0 (bubble), other fields hold, FSM<=BUBBLE.
  4. Otherwise, load the decoded input; ds_o_ce<=ds_i_ce, FSM<=RUN.
- ds_o_flush<=0 whenever ds_i_flush=0.
- BUBBLE state lasts exactly one cycle. Fetch holds the instruction while ds_o_stall=1, so the instruction issues next cycle without re-checking the hazard.
- ds_i_stall during BUBBLE: FSM stays BUBBLE until the stall releases.
- ds_i_ce=0: ds_o_ce<=0 (unless stalled).

Optional Feature:
DS_WB_BYPASS_EN
- Defined: if ds_i_wb_we & ds_i_wb_addr!=0 & ds_i_wb_addr equals rs1/rs2 in the same cycle, the operand captured is ds_i_wb_data.
- Undefined: the operand is the pre-write array value. The downstream forwarding network must cover this case.

Decomposition:
- Shared package/header holds the opcode constants, OPCODE_WIDTH/ALU_WIDTH/EXCEPTION_WIDTH, one-hot bit indices and FSM state encodings.
- Natural sub-module: ds_regfile (DEPTH x DWIDTH, 2 read ports, 1 write port, x0=0, optional bypass).
- Decode and hazard logic stay in the top.

Test Plan:
- Write x2=5, x3=7; then add x1,x2,x3 (0x003100B3) at pc=4 with ds_i_ce=1 -> next cycle: ds_o_ce=1, pc=4, rs1_p=2, rs2_p=3, rd_p=1, data1=5, data2=7, funct3=000, alu=ADD, opcode=RTYPE, exception=0.
- lw x5,8(x0), then add x6,x5,x1 -> ds_o_stall=1 for 1 cycle, a bubble (ds_o_ce=0), then the add issues with rs1_p=5; x0 as load rd -> no stall.
- Assert ds_i_flush with a valid instruction -> next cycle ds_o_ce=0, ds_o_flush=1; the cycle after, ds_o_flush=0.
- Hold ds_i_stall=1 for 3 cycles while changing ds_i_instr -> outputs frozen, ds_o_stall=1; the new instruction appears 1 cycle after release.
- Write x4=0xDEADBEEF in the same cycle as decoding addi x7,x4,-1 -> data1=0xDEADBEEF with DS_WB_BYPASS_EN, old x4 without; imm=0xFFFFFFFF.
- Opcode 0x7F -> illegal=1. ecall (0x00000073) -> ecall bit=1. Drop ds_rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
